// File: rtl/pattern_gen_pkg.sv
// Shared encodings for the serial pattern generator: trigger modes, FSM states
// and the length clamp used by both the FSM and the bit counter.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_RETRIG  = 2'b01,
    MODE_LOOP    = 2'b10,
    MODE_QUEUED  = 2'b11
  } pg_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pg_state_e;

  // Lengths at or beyond the pattern register size fold onto the last bit.
  function automatic int unsigned clamp_len(int unsigned len, int unsigned width);
    return (len >= width) ? width - 1 : len;
  endfunction

endpackage

// File: rtl/pattern_gen_if.sv
// Trigger/pattern bundle and serial output of pattern_gen, plus FSM state for checkers.
interface pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int LW    = 3
);
  import pattern_gen_pkg::*;

  // a is a level trigger sampled on every rising CLK edge; there is no ready.
  // The master may hold a, pat, len and mode at any time; the generator only
  // accepts them on an edge where it latches (idle trigger or a restart), and
  // busy tells the master whether a pattern is currently being emitted.
  logic             a;
  logic [WIDTH-1:0] pat;
  logic [LW-1:0]    len;
  logic [1:0]       mode;
  logic             s;
  logic             busy;
  logic             done;
  pg_state_e        state;

  modport master (output a, pat, len, mode, input s, busy, done, state);
  modport slave  (input a, pat, len, mode, output s, busy, done, state);

endinterface

// File: rtl/pattern_gen_ctr.sv
// Bit index counter: restarts at 0, steps by one and wraps after the clamped length.
module pattern_gen_ctr
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LW    = 3
) (
  input  logic          CLK,
  input  logic          nR,
  input  logic          start,
  input  logic          step,
  input  logic [LW-1:0] len,
  output logic [LW-1:0] idx_nxt,
  output logic          last
);

  logic [LW-1:0] idx;
  logic [LW-1:0] len_c;

  assign len_c = LW'(clamp_len(32'(len), WIDTH));
  assign last  = (idx == len_c);

  always_comb begin
    idx_nxt = idx;
    if (start) begin
      idx_nxt = '0;
    end else if (step) begin
      idx_nxt = last ? '0 : idx + LW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nR) begin
    if (!nR) begin
      idx <= '0;
    end else begin
      idx <= idx_nxt;
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// Serial pattern generator: FSM, input latches and registered s/busy/done.
// Outputs are computed from next-state values so they change on the same edge as the FSM.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   LW       = 3,
  parameter logic IDLE_VAL = 1'b0
) (
  input logic            CLK,
  input logic            nR,
  pattern_gen_if.slave   bus
);

  pg_state_e        st, st_n;
  logic             pend, pend_n;
  logic             load, step;
  logic [WIDTH-1:0] pat_q, pat_n;
  logic [LW-1:0]    len_q, len_n;
  pg_mode_e         mode_q, mode_n;
  logic [LW-1:0]    idx_nxt;
  logic             last;
  logic             s_q, busy_q, done_q;
  logic             s_n, busy_n, done_n;

  pattern_gen_ctr #(.WIDTH(WIDTH), .LW(LW)) u_ctr (
    .CLK     (CLK),
    .nR      (nR),
    .start   (load),
    .step    (step),
    .len     (len_q),
    .idx_nxt (idx_nxt),
    .last    (last)
  );

  always_comb begin
    st_n   = st;
    pend_n = pend;
    load   = 1'b0;
    step   = 1'b0;
    case (st)
      ST_IDLE: begin
        if (bus.a) begin
          load = 1'b1;
          st_n = ST_RUN;
        end
      end
      ST_RUN: begin
        case (mode_q)
          MODE_ONESHOT: begin
            if (last) st_n = ST_IDLE;
            else      step = 1'b1;
          end
          MODE_RETRIG: begin
            if (bus.a)     load = 1'b1;
            else if (last) st_n = ST_IDLE;
            else           step = 1'b1;
          end
          MODE_LOOP: begin
            if (last) begin
              if (bus.a) load = 1'b1;
              else       st_n = ST_IDLE;
            end else begin
              step = 1'b1;
            end
          end
          MODE_QUEUED: begin
            // A trigger on the final bit counts as queued and restarts directly.
            if (last) begin
              if (pend || bus.a) begin
                load   = 1'b1;
                pend_n = 1'b0;
              end else begin
                st_n = ST_IDLE;
              end
            end else begin
              step = 1'b1;
              if (bus.a) pend_n = 1'b1;
            end
          end
          default: st_n = ST_IDLE;
        endcase
      end
      default: st_n = ST_IDLE;
    endcase
  end

  always_comb begin
    pat_n  = load ? bus.pat : pat_q;
    len_n  = load ? bus.len : len_q;
    mode_n = load ? pg_mode_e'(bus.mode) : mode_q;
    busy_n = (st_n == ST_RUN);
    s_n    = busy_n ? pat_n[idx_nxt] : IDLE_VAL;
    done_n = busy_n && (idx_nxt == LW'(clamp_len(32'(len_n), WIDTH)));
  end

  always_ff @(posedge CLK or negedge nR) begin
    if (!nR) begin
      st     <= ST_IDLE;
      pend   <= 1'b0;
      pat_q  <= '0;
      len_q  <= '0;
      mode_q <= MODE_ONESHOT;
      s_q    <= IDLE_VAL;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st     <= st_n;
      pend   <= pend_n;
      pat_q  <= pat_n;
      len_q  <= len_n;
      mode_q <= mode_n;
      s_q    <= s_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  assign bus.s     = s_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = st;

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: directed scenarios plus randomized traffic, both checked
// against a bit-queue reference model of the trigger modes.
module tb_pattern_gen;
  import pattern_gen_pkg::*;

  localparam logic IV = 1'b1;

  logic CLK = 1'b0;
  logic nR;
  always #5 CLK = ~CLK;

  pattern_gen_if #(.WIDTH(8), .LW(3)) bus ();
  pattern_gen_if #(.WIDTH(3), .LW(2)) bus3 ();

  pattern_gen #(.WIDTH(8), .LW(3), .IDLE_VAL(IV)) dut (
    .CLK (CLK),
    .nR  (nR),
    .bus (bus)
  );

  pattern_gen #(.WIDTH(3), .LW(2), .IDLE_VAL(1'b0)) dut3 (
    .CLK (CLK),
    .nR  (nR),
    .bus (bus3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: remaining bits of the running pattern, front = bit on s now
  logic [0:0]  exp_q[$];
  logic        m_run  = 1'b0;
  logic        m_pend = 1'b0;
  logic [1:0]  m_mode = 2'b00;

  string       scen = "reset";
  int          k;
  logic [31:0] s_log, b_log, d_log, s3_log, b3_log, d3_log;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", scen, tag, obs, exp);
    end
  endtask

  task automatic m_load();
    int last_bit;
    last_bit = (int'(bus.len) >= 8) ? 7 : int'(bus.len);
    exp_q.delete();
    for (int i = 0; i <= last_bit; i++) exp_q.push_back(bus.pat[i]);
    m_mode = bus.mode;
    m_run  = 1'b1;
  endtask

  task automatic m_finish();
    m_run = 1'b0;
    exp_q.delete();
  endtask

  task automatic m_edge();
    logic fin;
    if (!m_run) begin
      if (bus.a) m_load();
    end else begin
      fin = (exp_q.size() == 1);
      case (m_mode)
        2'b00: if (fin) m_finish(); else void'(exp_q.pop_front());
        2'b01: begin
          if (bus.a)    m_load();
          else if (fin) m_finish();
          else          void'(exp_q.pop_front());
        end
        2'b10: begin
          if (fin) begin
            if (bus.a) m_load(); else m_finish();
          end else begin
            void'(exp_q.pop_front());
          end
        end
        default: begin
          if (fin) begin
            if (m_pend || bus.a) begin
              m_load();
              m_pend = 1'b0;
            end else begin
              m_finish();
            end
          end else begin
            if (bus.a) m_pend = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      endcase
    end
  endtask

  task automatic check_main();
    chk("s",     32'(bus.s),     32'(m_run ? exp_q[0] : IV));
    chk("busy",  32'(bus.busy),  32'(m_run));
    chk("done",  32'(bus.done),  32'(m_run && exp_q.size() == 1));
    chk("state", 32'(bus.state), 32'(m_run ? ST_RUN : ST_IDLE));
  endtask

  task automatic start_log(input string nm);
    scen = nm;
    k = 0;
    s_log = '0; b_log = '0; d_log = '0;
    s3_log = '0; b3_log = '0; d3_log = '0;
  endtask

  task automatic cyc(input logic a_v, input logic a3_v);
    bus.a  = a_v;
    bus3.a = a3_v;
    @(posedge CLK);
    m_edge();
    #1;
    check_main();
    if (k < 32) begin
      s_log[k]  = bus.s;  b_log[k]  = bus.busy;  d_log[k]  = bus.done;
      s3_log[k] = bus3.s; b3_log[k] = bus3.busy; d3_log[k] = bus3.done;
    end
    k++;
  endtask

  initial begin
    nR = 1'b0;
    bus.a = 1'b0;  bus.pat = '0;  bus.len = '0;  bus.mode = '0;
    bus3.a = 1'b0; bus3.pat = '0; bus3.len = '0; bus3.mode = '0;

    repeat (2) @(posedge CLK);
    #1;
    check_main();
    chk("s3", 32'(bus3.s), 32'd0);
    #2 nR = 1'b1;

    // 3-bit pattern 101, one-shot; mirrored on the 3-bit instance
    bus.pat = 8'b101;  bus.len = 3'd2;  bus.mode = 2'b00;
    bus3.pat = 3'b101; bus3.len = 2'd2; bus3.mode = 2'b00;
    start_log("r028");
    cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b0);
    chk("s_seq",  s_log[3:0],  4'b1101);
    chk("b_seq",  b_log[3:0],  4'b0111);
    chk("d_seq",  d_log[3:0],  4'b0100);
    chk("s3_seq", s3_log[3:0], 4'b0101);
    chk("b3_seq", b3_log[3:0], 4'b0111);
    chk("d3_seq", d3_log[3:0], 4'b0100);

    // len beyond the 3-bit register clamps to the last bit
    bus3.len = 2'd3;
    start_log("clamp");
    cyc(1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0);
    chk("s3_seq", s3_log[3:0], 4'b0101);
    chk("b3_seq", b3_log[3:0], 4'b0111);
    chk("d3_seq", d3_log[3:0], 4'b0100);

    // retrigger at idx 4 aborts the first run
    bus.pat = 8'hA5; bus.len = 3'd7; bus.mode = 2'b01;
    start_log("r029");
    for (int i = 0; i < 14; i++) cyc(i == 0 || i == 5, 1'b0);
    chk("s_seq", s_log[13:0], 14'b11010010100101);
    chk("b_seq", b_log[13:0], 14'h1FFF);
    chk("n_done", 32'($countones(d_log)), 32'd1);

    // queued: first extra trigger replays, second is dropped
    bus.pat = 8'h0F; bus.len = 3'd3; bus.mode = 2'b11;
    start_log("r030");
    for (int i = 0; i < 9; i++) cyc(i == 0 || i == 2 || i == 3, 1'b0);
    chk("s_seq", s_log[8:0], 9'b111111111);
    chk("b_seq", b_log[8:0], 9'h0FF);
    chk("d_seq", d_log[8:0], 9'b010001000);

    // loop while a is held
    bus.pat = 8'b10; bus.len = 3'd1; bus.mode = 2'b10;
    start_log("r031");
    for (int i = 0; i < 12; i++) cyc(i < 10, 1'b0);
    chk("s_seq", s_log[11:0], 12'b111010101010);
    chk("b_seq", b_log[11:0], 12'h3FF);
    chk("d_seq", d_log[11:0], 12'b001010101010);

    // asynchronous reset in the middle of a run
    bus.pat = 8'hA5; bus.len = 3'd7; bus.mode = 2'b00;
    start_log("r032");
    cyc(1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b0);
    #2 nR = 1'b0;
    #1;
    m_pend = 1'b0;
    m_finish();
    chk("rst_s",     32'(bus.s),     32'(IV));
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_state", 32'(bus.state), 32'(ST_IDLE));
    #2 nR = 1'b1;
    bus.pat = 8'h5A;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("restart_s", 32'(bus.s), 32'd0);
    repeat (8) cyc(1'b0, 1'b0);
    chk("n_done", 32'($countones(d_log)), 32'd1);

    // randomized traffic; mode/pat/len change freely during runs
    start_log("rand");
    for (int i = 0; i < 600; i++) begin
      bus.pat  = 8'($urandom);
      bus.len  = 3'($urandom_range(0, 7));
      bus.mode = 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 3) == 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: maximum pattern length in bits (>=2).
REQ-002 The block SHALL have parameter LW, default 3: width of len, equal to clog2(WIDTH).
REQ-003 The block SHALL have parameter IDLE_VAL, default 0: value driven on s when not running.
REQ-004 The block SHALL have port CLK, input, 1 bit: sole clock, rising edge active.
REQ-005 The block SHALL have port nR, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port a, input, 1 bit: trigger, sampled on CLK rising edge.
REQ-007 The block SHALL have port pat, input, WIDTH bits: pattern, bit 0 emitted first.
REQ-008 The block SHALL have port len, input, LW bits: pattern length minus 1; values >= WIDTH clamp to WIDTH-1.
REQ-009 The block SHALL have port mode, input, 2 bits: 00 one-shot, 01 retrigger, 10 loop, 11 queued.
REQ-010 The block SHALL have port s, output, 1 bit: serial pattern output, driven only from registers.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a pattern is being emitted.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse coincident with the final bit of a completed pattern.

Function
REQ-013 The FSM SHALL have two states: IDLE and RUN, plus bit index idx (LW bits) and a 1-bit pending flag.
REQ-014 In IDLE with a=1 at an edge, the block SHALL latch pat, len and mode, set idx=0 and enter RUN; s=pat[0] and busy=1 from that edge (1-cycle latency).
REQ-015 In RUN, s SHALL equal latched pat[idx]; idx SHALL increment by 1 per cycle up to latched len.
REQ-016 At idx==len, done SHALL be 1; at the following edge the block SHALL return to IDLE unless REQ-018 to REQ-020 restart it.
REQ-017 Mode 00: a during RUN SHALL be ignored.
REQ-018 Mode 01: a=1 during RUN, including the final bit, SHALL relatch pat/len/mode and restart at idx=0 next cycle; done SHALL NOT pulse on an aborted run.
REQ-019 Mode 10: at idx==len, if a=1 then idx SHALL wrap to 0 with no idle cycle, relatching pat/len/mode; done pulses on every completed pass.
REQ-020 Mode 11: a=1 during RUN, including the final bit, SHALL set pending (depth 1; further triggers dropped); at idx==len with pending=1, the block SHALL restart at idx=0 next cycle, relatch inputs and clear pending.
REQ-021 In IDLE, s SHALL equal IDLE_VAL, busy=0 and done=0.
REQ-022 len=0 SHALL emit a single bit with busy and done high for one cycle.
REQ-023 A mode change on the mode input during RUN SHALL have no effect until the next latch.

Reset
REQ-024 nR=0 SHALL immediately force IDLE, idx=0, pending=0, s=IDLE_VAL, busy=0 and done=0, asynchronously to CLK.
REQ-025 Reset during RUN SHALL abort the pattern with no done pulse; the first trigger after nR rises SHALL behave per REQ-014.

Structure
REQ-026 A shared package SHALL hold the mode encodings (MODE_ONESHOT, MODE_RETRIG, MODE_LOOP, MODE_QUEUED) and the state encodings (ST_IDLE, ST_RUN).
REQ-027 The bit index counter with clamp and wrap SHALL be the sub-module pattern_gen_ctr; FSM, latches and output registers SHALL stay in pattern_gen.

Verification
REQ-028 WIDTH=3, pat=3'b101, len=2, mode=00, a pulsed 1 cycle: s = 1,0,1 then IDLE_VAL; busy high 3 cycles; done on cycle 3.
REQ-029 pat=8'hA5, len=7, mode=01, second trigger at idx=4: s = 1,0,1,0,0 then 1,0,1,0,0,1,0,1; exactly one done.
REQ-030 pat=8'h0F, len=3, mode=11, triggers at idx=1 and idx=2: the pattern plays twice back-to-back (1,1,1,1,1,1,1,1); two done pulses; the second trigger is dropped.
REQ-031 mode=10, a held high for 10 cycles, len=1, pat=2'b10: s = 0,1,0,1,... with done every 2nd cycle; return to IDLE after the pass that sees a=0.
REQ-032 nR asserted mid-cycle at idx=2: outputs reach reset values before the next edge; no done pulse; a new trigger after release restarts from pat[0].
